// File: rtl/vliw_pkg.sv
// Shared types and helpers for the VLIW instruction-memory fetch block.
package vliw_pkg;

    typedef enum logic [1:0] {
        PROG  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int HW_WIDTH_DEF = 16;
    localparam int DEPTH_DEF    = 32;
    localparam int ISSUE_DEF    = 2;

    typedef struct packed {
        logic        hit;
        logic [31:0] idx;
    } lane_pick_t;

    // Maps a lane address onto a storage index; a miss means the lane reads as zero.
    function automatic lane_pick_t lane_pick(input logic [31:0] a, input logic [31:0] depth,
                                             input logic wrap);
        lane_pick_t p;
        p.hit = 1'b0;
        p.idx = '0;
        if (a < depth) begin
            p.hit = 1'b1;
            p.idx = a;
        end else if (wrap) begin
            p.hit = 1'b1;
            p.idx = a - depth;
        end
        return p;
    endfunction

endpackage

// File: rtl/vliw_imem_lane_sel.sv
// One bundle lane: selects mem[pc+LANE] with wrap-or-zero handling past the end.
module vliw_imem_lane_sel
    import vliw_pkg::*;
#(
    parameter int HW_WIDTH = HW_WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int WRAP     = 0,
    parameter int LANE     = 0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [HW_WIDTH-1:0] mem [DEPTH],
    input  logic [AW-1:0]       pc,
    output logic [HW_WIDTH-1:0] data
);

    logic [AW+3:0] addr;
    lane_pick_t    pick;

    always_comb begin
        addr = (AW+4)'(pc) + (AW+4)'(LANE);
        pick = lane_pick(32'(addr), 32'(DEPTH), WRAP != 0);
        data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (pick.hit && pick.idx == 32'(i))
                data = mem[i[AW-1:0]];
        end
    end

endmodule

// File: rtl/vliw_imem_fetch.sv
// Instruction memory with a halted-core load port and a stallable one-cycle bundle fetch port.
module vliw_imem_fetch
    import vliw_pkg::*;
#(
    parameter int HW_WIDTH = HW_WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ISSUE    = ISSUE_DEF,
    parameter int WRAP     = 0,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ld_valid,
    input  logic [AW-1:0]             ld_addr,
    input  logic [HW_WIDTH-1:0]       ld_data,
    output logic                      ld_ready,
    input  logic                      go,
    input  logic                      halt,
    input  logic                      fetch_req,
    input  logic [AW-1:0]             fetch_pc,
    output logic                      fetch_ready,
    output logic                      bundle_valid,
    output logic [ISSUE*HW_WIDTH-1:0] bundle,
    input  logic                      bundle_ready,
    output logic                      oob_err,
    output logic [1:0]                state
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t                     st;
    logic [HW_WIDTH-1:0]        mem  [DEPTH];
    logic [HW_WIDTH-1:0]        lane [ISSUE];
    logic [ISSUE*HW_WIDTH-1:0]  next_bundle;
    logic                       ld_fire;
    logic                       fetch_fire;
    logic                       ld_in_range;
    logic                       pc_in_range;

    for (genvar k = 0; k < ISSUE; k++) begin : g_lane
        vliw_imem_lane_sel #(
            .HW_WIDTH(HW_WIDTH),
            .DEPTH   (DEPTH),
            .WRAP    (WRAP),
            .LANE    (k)
        ) u_lane (
            .mem (mem),
            .pc  (fetch_pc),
            .data(lane[k])
        );
    end

    always_comb begin
        ld_ready    = (st == PROG);
        // halt blocks acceptance in the same cycle so no new bundle enters the drain
        fetch_ready = (st == RUN) && !halt && (!bundle_valid || bundle_ready);
        ld_fire     = ld_valid && ld_ready;
        fetch_fire  = fetch_req && fetch_ready;
        ld_in_range = {1'b0, ld_addr} < DEPTH_W;
        pc_in_range = {1'b0, fetch_pc} < DEPTH_W;
        state       = st;
        next_bundle = '0;
        for (int unsigned k = 0; k < ISSUE; k++) begin
            if (pc_in_range)
                next_bundle[k*HW_WIDTH +: HW_WIDTH] = lane[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st           <= PROG;
            bundle_valid <= 1'b0;
            bundle       <= '0;
            oob_err      <= 1'b0;
            mem          <= '{default: '0};
        end else begin
            if (ld_fire) begin
                if (ld_in_range)
                    mem[ld_addr] <= ld_data;
                else
                    oob_err <= 1'b1;
            end

            if (fetch_fire) begin
                bundle_valid <= 1'b1;
                bundle       <= next_bundle;
                if (!pc_in_range)
                    oob_err <= 1'b1;
            end else if (bundle_valid && bundle_ready) begin
                bundle_valid <= 1'b0;
            end

            unique case (st)
                PROG:    if (go) st <= RUN;
                RUN:     if (halt) st <= DRAIN;
                DRAIN:   if (!bundle_valid || bundle_ready) st <= PROG;
                default: st <= PROG;
            endcase
        end
    end

endmodule

// File: tb/tb_vliw_imem_fetch.sv
// Scoreboard bench: two instances (DEPTH=32/no wrap, DEPTH=20/wrap) share stimulus, each with its own model.
module tb_vliw_imem_fetch;

    localparam int HW    = 16;
    localparam int ISSUE = 2;
    localparam int AW    = 5;
    localparam int BW    = ISSUE * HW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset        = 1'b1;
    logic          ld_valid     = 1'b0;
    logic          go           = 1'b0;
    logic          halt         = 1'b0;
    logic          fetch_req    = 1'b0;
    logic          bundle_ready = 1'b1;
    logic [AW-1:0] ld_addr      = '0;
    logic [AW-1:0] fetch_pc     = '0;
    logic [HW-1:0] ld_data      = '0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : ch
        localparam int D = (g == 0) ? 32 : 20;
        localparam int W = g;

        logic          fr, lr, bv, oob;
        logic [1:0]    st;
        logic [BW-1:0] bun;

        vliw_imem_fetch #(
            .HW_WIDTH(HW),
            .DEPTH   (D),
            .ISSUE   (ISSUE),
            .WRAP    (W)
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .ld_valid    (ld_valid),
            .ld_addr     (ld_addr),
            .ld_data     (ld_data),
            .ld_ready    (lr),
            .go          (go),
            .halt        (halt),
            .fetch_req   (fetch_req),
            .fetch_pc    (fetch_pc),
            .fetch_ready (fr),
            .bundle_valid(bv),
            .bundle      (bun),
            .bundle_ready(bundle_ready),
            .oob_err     (oob),
            .state       (st)
        );

        // Reference model: memory image, expected in-flight bundles, last delivered bundle.
        logic [HW-1:0] m [32];
        logic [BW-1:0] q [$];
        logic [BW-1:0] last;
        int            mst;
        bit            moob;
        bit            armed = 1'b0;

        function automatic logic [BW-1:0] expect_bundle(input int pc);
            logic [BW-1:0] r;
            r = '0;
            if (pc < D) begin
                for (int k = 0; k < ISSUE; k++) begin
                    int a;
                    a = pc + k;
                    if (a < D)
                        r[k*HW +: HW] = m[a[4:0]];
                    else if (W == 1)
                        r[k*HW +: HW] = m[5'(a - D)];
                end
            end
            return r;
        endfunction

        always @(negedge clk) begin : mon
            bit efr;
            efr = (mst == 1) && !halt && (q.size() == 0 || bundle_ready);
            if (armed) begin
                check($sformatf("ch%0d state", g), 32'(st), 32'(mst));
                check($sformatf("ch%0d ld_ready", g), 32'(lr), 32'(mst == 0));
                check($sformatf("ch%0d fetch_ready", g), 32'(fr), 32'(efr));
                check($sformatf("ch%0d bundle_valid", g), 32'(bv), 32'(q.size() != 0));
                check($sformatf("ch%0d oob_err", g), 32'(oob), 32'(moob));
                if (q.size() != 0)
                    check($sformatf("ch%0d bundle", g), bun, q[0]);
                else
                    check($sformatf("ch%0d bundle_hold", g), bun, last);
            end
            if (reset) begin
                for (int i = 0; i < 32; i++) m[i] = '0;
                q.delete();
                last  = '0;
                mst   = 0;
                moob  = 1'b0;
                armed = 1'b1;
            end else if (armed) begin
                case (mst)
                    0: begin
                        if (ld_valid) begin
                            if (int'(ld_addr) < D) m[ld_addr] = ld_data;
                            else moob = 1'b1;
                        end
                        if (go) mst = 1;
                    end
                    1: begin
                        if (q.size() != 0 && bundle_ready) last = q.pop_front();
                        if (fetch_req && efr) begin
                            q.push_back(expect_bundle(int'(fetch_pc)));
                            if (int'(fetch_pc) >= D) moob = 1'b1;
                        end
                        if (halt) mst = 2;
                    end
                    default: begin
                        if (q.size() == 0 || bundle_ready) begin
                            if (q.size() != 0) last = q.pop_front();
                            mst = 0;
                        end
                    end
                endcase
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [HW-1:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        cyc(1);
        ld_valid = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] pc);
        fetch_req = 1'b1;
        fetch_pc  = pc;
        cyc(1);
        fetch_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);

        load(5'd0, 16'h8033);
        load(5'd1, 16'h0020);
        load(5'd31, 16'hABCD);
        load(5'd19, 16'hABCD);
        load(5'd25, 16'h5555);

        go = 1'b1; ld_valid = 1'b1; ld_addr = 5'd2; ld_data = 16'h7777;
        cyc(1);
        go = 1'b0; ld_valid = 1'b0;
        cyc(1);

        fetch(5'd0);
        fetch(5'd31);
        fetch(5'd19);
        fetch(5'd25);
        fetch(5'd2);
        cyc(2);

        ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 16'hDEAD;
        cyc(2);
        ld_valid = 1'b0;
        fetch(5'd0);
        cyc(1);

        fetch_req = 1'b1; fetch_pc = 5'd0;
        cyc(1);
        bundle_ready = 1'b0; fetch_pc = 5'd2;
        cyc(3);
        bundle_ready = 1'b1;
        cyc(1);
        fetch_req = 1'b0;
        cyc(2);

        fetch_req = 1'b1; fetch_pc = 5'd1;
        cyc(1);
        bundle_ready = 1'b0; halt = 1'b1;
        cyc(1);
        halt = 1'b0; fetch_req = 1'b0;
        cyc(2);
        bundle_ready = 1'b1;
        cyc(2);

        go = 1'b1;
        cyc(1);
        go = 1'b0;
        fetch_req = 1'b1; fetch_pc = 5'd3; bundle_ready = 1'b0;
        cyc(1);
        fetch_req = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0; bundle_ready = 1'b1; go = 1'b1;
        cyc(1);
        go = 1'b0;
        fetch(5'd0);
        fetch(5'd1);
        fetch(5'd19);
        fetch(5'd31);
        cyc(2);
        halt = 1'b1;
        cyc(1);
        halt = 1'b0;
        cyc(2);

        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 199) == 0);
            go           = ($urandom_range(0, 19) == 0);
            halt         = ($urandom_range(0, 29) == 0);
            ld_valid     = ($urandom_range(0, 1) == 1);
            ld_addr      = 5'($urandom);
            ld_data      = 16'($urandom);
            fetch_req    = ($urandom_range(0, 3) != 0);
            fetch_pc     = 5'($urandom);
            bundle_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end

        reset = 1'b0; go = 1'b0; halt = 1'b0; ld_valid = 1'b0; fetch_req = 1'b0; bundle_ready = 1'b1;
        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
